// File: rtl/mem_access_unit.sv
// Load/store sequencer between CPU control and a word-wide synchronous memory.
// Handles register/memory byte-lane reversal and read-modify-write for sub-word stores.
//
// state  | meaning
// IDLE   | ready for a request
// RD     | word address held, waiting RD_LATENCY cycles for read data
// CAP    | read data registered at end of cycle
// WR     | single-cycle memory write
// RESP   | one-cycle response pulse
module mem_access_unit #(
   parameter int RD_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic [31:0] mem_addr,
   output logic        mem_wr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_excp
);
   localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

   localparam logic [2:0] OP_SB = 3'b000;
   localparam logic [2:0] OP_SH = 3'b010;
   localparam logic [2:0] OP_SW = 3'b001;
   localparam logic [2:0] OP_LW = 3'b100;
   localparam logic [2:0] OP_LH = 3'b101;
   localparam logic [2:0] OP_LB = 3'b011;

   typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_RESP} state_t;

   function automatic logic [31:0] byte_rev(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   function automatic logic is_excp(input logic [2:0] op, input logic [1:0] a);
      case (op)
         OP_LH, OP_SH: is_excp = a[0];
         OP_LW, OP_SW: is_excp = |a;
         OP_LB, OP_SB: is_excp = 1'b0;
         default:      is_excp = 1'b1;
      endcase
   endfunction

   function automatic logic is_load(input logic [2:0] op);
      return (op == OP_LW) || (op == OP_LH) || (op == OP_LB);
   endfunction

   state_t         state, state_nxt;
   logic [2:0]     op_q;
   logic [1:0]     addr_q;
   logic [31:0]    wdata_q;
   logic [31:0]    rdata_q;
   logic           excp_q;
   logic [CW-1:0]  cnt;
   logic           accept;
   logic           req_excp;
   logic [31:0]    wr_word;
   logic [31:0]    reg_word;
   logic [31:0]    ld_word;

   assign accept   = (state == S_IDLE) && req_valid;
   assign req_excp = is_excp(req_op, req_addr[1:0]);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         op_q     <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         excp_q   <= 1'b0;
         cnt      <= '0;
         mem_addr <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op_q    <= req_op;
            addr_q  <= req_addr[1:0];
            wdata_q <= req_wdata;
            excp_q  <= req_excp;
            cnt     <= CW'(RD_LATENCY - 1);
            // exceptions must leave the memory address untouched
            if (!req_excp)
               mem_addr <= {req_addr[31:2], 2'b00};
         end else if ((state == S_RD) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
         end
         if (state == S_CAP)
            rdata_q <= mem_rdata;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (req_valid) begin
               if (req_excp)              state_nxt = S_RESP;
               else if (req_op == OP_SW)  state_nxt = S_WR;
               else                       state_nxt = S_RD;
            end
         end
         S_RD:    if (cnt == '0) state_nxt = S_CAP;
         S_CAP:   state_nxt = is_load(op_q) ? S_RESP : S_WR;
         S_WR:    state_nxt = S_RESP;
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready  = 1'b0;
      mem_wr     = 1'b0;
      mem_wdata  = '0;
      resp_valid = 1'b0;
      resp_rdata = '0;
      resp_excp  = 1'b0;

      // register byte k lives in memory lane 3-k
      wr_word = rdata_q;
      case (op_q)
         OP_SW: wr_word = byte_rev(wdata_q);
         OP_SH: begin
            if (addr_q[1]) wr_word[15:0]  = {wdata_q[7:0], wdata_q[15:8]};
            else           wr_word[31:16] = {wdata_q[7:0], wdata_q[15:8]};
         end
         OP_SB: wr_word[{~addr_q, 3'b000} +: 8] = wdata_q[7:0];
         default: ;
      endcase

      reg_word = byte_rev(rdata_q);
      case (op_q)
         OP_LW:   ld_word = reg_word;
         OP_LH:   ld_word = {16'h0000, reg_word[{addr_q[1], 4'b0000} +: 16]};
         OP_LB:   ld_word = {24'h000000, reg_word[{addr_q, 3'b000} +: 8]};
         default: ld_word = '0;
      endcase

      case (state)
         S_IDLE: req_ready = 1'b1;
         S_WR: begin
            mem_wr    = 1'b1;
            mem_wdata = wr_word;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            resp_excp  = excp_q;
            if (!excp_q)
               resp_rdata = ld_word;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (RD_LATENCY 1 and 3) run the same directed
// requests against a behavioural memory and an access-level reference model.
module tb_mem_access_unit;
   localparam logic [2:0] OP_SB = 3'b000;
   localparam logic [2:0] OP_SH = 3'b010;
   localparam logic [2:0] OP_SW = 3'b001;
   localparam logic [2:0] OP_LW = 3'b100;
   localparam logic [2:0] OP_LH = 3'b101;
   localparam logic [2:0] OP_LB = 3'b011;
   localparam int RDL0 = 1;
   localparam int RDL1 = 3;

   logic        clk = 1'b0;
   logic [1:0]  rstn;
   logic [1:0]  req_valid;
   logic [1:0]  rdy;
   logic [1:0]  mem_wr;
   logic [1:0]  resp_valid;
   logic [1:0]  resp_excp;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] maddr  [2];
   logic [31:0] mwdata [2];
   logic [31:0] mrdata [2];
   logic [31:0] rrdata [2];

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] mem     [2][64];
   logic [31:0] ref_mem [2][64];
   logic [31:0] pipe1   [2];

   int          cyc = 0;
   int          busy [2];
   int          ex_lat [2];
   logic        ex_store [2];
   logic        ex_excp [2];
   logic [31:0] ex_rdata [2];
   logic [31:0] ex_wdata [2];
   logic [31:0] last_addr [2];

   int          acc_cyc [2];
   int          acc_count [2];
   int          resp_count [2];
   int          obs_lat [2];
   int          obs_wcnt [2];
   logic [31:0] obs_rdata [2];
   logic [31:0] obs_wdata [2];
   logic [31:0] obs_waddr [2];
   logic        obs_excp [2];

   always #5 clk = ~clk;

   mem_access_unit #(.RD_LATENCY(RDL0)) u_dut0 (
      .clk(clk), .reset_n(rstn[0]), .req_valid(req_valid[0]), .req_ready(rdy[0]),
      .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
      .mem_addr(maddr[0]), .mem_wr(mem_wr[0]), .mem_wdata(mwdata[0]), .mem_rdata(mrdata[0]),
      .resp_valid(resp_valid[0]), .resp_rdata(rrdata[0]), .resp_excp(resp_excp[0])
   );

   mem_access_unit #(.RD_LATENCY(RDL1)) u_dut1 (
      .clk(clk), .reset_n(rstn[1]), .req_valid(req_valid[1]), .req_ready(rdy[1]),
      .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
      .mem_addr(maddr[1]), .mem_wr(mem_wr[1]), .mem_wdata(mwdata[1]), .mem_rdata(mrdata[1]),
      .resp_valid(resp_valid[1]), .resp_rdata(rrdata[1]), .resp_excp(resp_excp[1])
   );

   function automatic logic [31:0] rev(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   function automatic logic model_excp(input logic [2:0] op, input logic [31:0] a);
      if (op == 3'b110 || op == 3'b111) return 1'b1;
      if (op == OP_LH || op == OP_SH) return a[0];
      if (op == OP_LW || op == OP_SW) return a[1:0] != 2'b00;
      return 1'b0;
   endfunction

   function automatic logic model_store(input logic [2:0] op);
      return op == OP_SB || op == OP_SH || op == OP_SW;
   endfunction

   function automatic int model_lat(input logic [2:0] op, input logic e, input int rdl);
      if (e) return 1;
      if (op == OP_SW) return 2;
      if (model_store(op)) return rdl + 3;
      return rdl + 2;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] word);
      logic [31:0] r;
      r = rev(word);
      if (op == OP_LW) return r;
      if (op == OP_LH) return (r >> (16 * int'(a[1]))) & 32'h0000FFFF;
      return (r >> (8 * int'(a[1:0]))) & 32'h000000FF;
   endfunction

   function automatic logic [31:0] model_store_word(input logic [2:0] op, input logic [31:0] a,
                                                    input logic [31:0] wd, input logic [31:0] word);
      logic [31:0] r;
      int s;
      r = rev(word);
      if (op == OP_SW) return rev(wd);
      if (op == OP_SH) begin
         s = 16 * int'(a[1]);
         r = (r & ~(32'h0000FFFF << s)) | ((wd & 32'h0000FFFF) << s);
      end else begin
         s = 8 * int'(a[1:0]);
         r = (r & ~(32'h000000FF << s)) | ((wd & 32'h000000FF) << s);
      end
      return rev(r);
   endfunction

   task automatic chk32(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", name, d, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input int d, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s dut%0d: got %b expected %b (t=%0t)", name, d, act, exp, $time);
      end
   endtask

   // memory environment and reference model, advanced on each rising edge
   initial begin
      logic        e;
      logic [31:0] w;
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 64; j++) begin
            mem[i][j]     = 32'hA5A5_0000 | 32'(j);
            ref_mem[i][j] = 32'hA5A5_0000 | 32'(j);
         end
         mem[i][0]     = 32'h44332211;
         ref_mem[i][0] = 32'h44332211;
         busy[i] = 0; ex_lat[i] = 1; ex_store[i] = 1'b0; ex_excp[i] = 1'b0;
         ex_rdata[i] = '0; ex_wdata[i] = '0; last_addr[i] = '0;
         acc_cyc[i] = 0; acc_count[i] = 0; resp_count[i] = 0; obs_lat[i] = -1; obs_wcnt[i] = 0;
         obs_rdata[i] = '0; obs_wdata[i] = '0; obs_waddr[i] = '0; obs_excp[i] = 1'b0;
      end
      forever begin
         @(posedge clk);
         cyc++;
         for (int i = 0; i < 2; i++) begin
            if (mem_wr[i] === 1'b1) mem[i][maddr[i][7:2]] = mwdata[i];
            if (rstn[i] && req_valid[i] && rdy[i]) begin
               acc_cyc[i] = cyc; acc_count[i]++; obs_wcnt[i] = 0; obs_lat[i] = -1;
               obs_rdata[i] = 32'hDEADBEEF;
            end
            if (!rstn[i]) begin
               busy[i] = 0;
               last_addr[i] = '0;
            end else if (busy[i] == 0) begin
               if (req_valid[i]) begin
                  e = model_excp(req_op, req_addr);
                  ex_excp[i]  = e;
                  ex_store[i] = !e && model_store(req_op);
                  ex_lat[i]   = model_lat(req_op, e, (i == 0) ? RDL0 : RDL1);
                  w = ref_mem[i][req_addr[7:2]];
                  ex_wdata[i] = model_store_word(req_op, req_addr, req_wdata, w);
                  ex_rdata[i] = (e || model_store(req_op)) ? 32'h0 : model_load(req_op, req_addr, w);
                  if (!e) last_addr[i] = {req_addr[31:2], 2'b00};
                  busy[i] = 1;
               end
            end else begin
               if (ex_store[i] && busy[i] == ex_lat[i] - 1)
                  ref_mem[i][last_addr[i][7:2]] = ex_wdata[i];
               busy[i] = (busy[i] == ex_lat[i]) ? 0 : busy[i] + 1;
            end
         end
         mrdata[0] <= mem[0][maddr[0][7:2]];
         pipe1[0]  <= mem[1][maddr[1][7:2]];
         pipe1[1]  <= pipe1[0];
         mrdata[1] <= pipe1[1];
      end
   end

   // per-cycle comparison against the model
   initial begin
      int   k;
      logic er, ew;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (rstn[i] === 1'b1) begin
               k  = busy[i];
               er = (k != 0) && (k == ex_lat[i]);
               ew = (k != 0) && ex_store[i] && (k == ex_lat[i] - 1);
               chk1("req_ready", i, rdy[i], k == 0);
               chk1("resp_valid", i, resp_valid[i], er);
               chk1("mem_wr", i, mem_wr[i], ew);
               chk32("mem_addr", i, maddr[i], last_addr[i]);
               if (ew) chk32("mem_wdata", i, mwdata[i], ex_wdata[i]);
               if (er) begin
                  chk32("resp_rdata", i, rrdata[i], ex_rdata[i]);
                  chk1("resp_excp", i, resp_excp[i], ex_excp[i]);
               end
               if (resp_valid[i] === 1'b1) begin
                  resp_count[i]++;
                  obs_rdata[i] = rrdata[i];
                  obs_excp[i]  = resp_excp[i];
                  obs_lat[i]   = cyc - acc_cyc[i] + 1;
               end
               if (mem_wr[i] === 1'b1) begin
                  obs_wcnt[i]++;
                  obs_wdata[i] = mwdata[i];
                  obs_waddr[i] = maddr[i];
               end
            end
         end
      end
   end

   task automatic wait_idle(input logic [1:0] mask);
      int n;
      n = 0;
      while (((mask[0] && busy[0] != 0) || (mask[1] && busy[1] != 0)) && n < 80) begin
         @(negedge clk);
         n++;
      end
      if (n >= 80) begin
         vectors++;
         miscompares++;
         $display("FAIL idle_timeout mask %b: still busy after %0d cycles", mask, n);
      end
   endtask

   task automatic run(input logic [1:0] mask, input logic [2:0] op, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] e_rdata, input logic e_excp,
                      input int e_lat0, input int e_lat1, input int e_wcnt,
                      input logic [31:0] e_wdata, input logic [31:0] e_waddr);
      wait_idle(2'b11);
      @(negedge clk);
      req_valid = mask; req_op = op; req_addr = addr; req_wdata = wd;
      @(negedge clk);
      req_valid = 2'b00; req_op = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
      @(negedge clk);
      wait_idle(mask);
      for (int i = 0; i < 2; i++) begin
         if (mask[i]) begin
            chk32("lit_rdata", i, obs_rdata[i], e_rdata);
            chk1("lit_excp", i, obs_excp[i], e_excp);
            chk32("lit_latency", i, 32'(obs_lat[i]), 32'((i == 0) ? e_lat0 : e_lat1));
            chk32("lit_wr_count", i, 32'(obs_wcnt[i]), 32'(e_wcnt));
            if (e_wcnt > 0) begin
               chk32("lit_wdata", i, obs_wdata[i], e_wdata);
               chk32("lit_waddr", i, obs_waddr[i], e_waddr);
            end
         end
      end
   endtask

   initial begin
      int a0 [2];
      int r0 [2];
      int rc;
      rstn = 2'b00; req_valid = 2'b00; req_op = '0; req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk1("rst_ready", i, rdy[i], 1'b1);
         chk1("rst_mem_wr", i, mem_wr[i], 1'b0);
         chk32("rst_mem_addr", i, maddr[i], 32'h0);
         chk32("rst_mem_wdata", i, mwdata[i], 32'h0);
         chk1("rst_resp_valid", i, resp_valid[i], 1'b0);
         chk32("rst_resp_rdata", i, rrdata[i], 32'h0);
         chk1("rst_resp_excp", i, resp_excp[i], 1'b0);
      end
      rstn = 2'b11;
      @(negedge clk);

      run(2'b11, OP_LW, 32'h100, 32'h0, 32'h11223344, 1'b0, 3, 5, 0, 32'h0, 32'h0);
      run(2'b11, OP_LB, 32'h101, 32'h0, 32'h00000033, 1'b0, 3, 5, 0, 32'h0, 32'h0);
      run(2'b11, OP_LB, 32'h103, 32'h0, 32'h00000011, 1'b0, 3, 5, 0, 32'h0, 32'h0);
      run(2'b11, OP_LH, 32'h102, 32'h0, 32'h00001122, 1'b0, 3, 5, 0, 32'h0, 32'h0);
      run(2'b11, OP_LH, 32'h100, 32'h0, 32'h00003344, 1'b0, 3, 5, 0, 32'h0, 32'h0);
      run(2'b11, OP_SB, 32'h102, 32'hAABBCCDD, 32'h0, 1'b0, 4, 6, 1, 32'h4433DD11, 32'h100);
      run(2'b11, OP_LB, 32'h102, 32'h0, 32'h000000DD, 1'b0, 3, 5, 0, 32'h0, 32'h0);
      run(2'b11, OP_SW, 32'h100, 32'h11223344, 32'h0, 1'b0, 2, 2, 1, 32'h44332211, 32'h100);
      run(2'b11, OP_SH, 32'h100, 32'h0000BEEF, 32'h0, 1'b0, 4, 6, 1, 32'hEFBE2211, 32'h100);
      run(2'b11, OP_LH, 32'h100, 32'h0, 32'h0000BEEF, 1'b0, 3, 5, 0, 32'h0, 32'h0);
      run(2'b11, OP_SW, 32'h104, 32'h11223344, 32'h0, 1'b0, 2, 2, 1, 32'h44332211, 32'h104);
      run(2'b11, OP_LW, 32'h104, 32'h0, 32'h11223344, 1'b0, 3, 5, 0, 32'h0, 32'h0);

      run(2'b11, OP_LW, 32'h102, 32'h0, 32'h0, 1'b1, 1, 1, 0, 32'h0, 32'h0);
      run(2'b11, OP_SH, 32'h101, 32'h1234, 32'h0, 1'b1, 1, 1, 0, 32'h0, 32'h0);
      run(2'b11, 3'b110, 32'h108, 32'h0, 32'h0, 1'b1, 1, 1, 0, 32'h0, 32'h0);
      run(2'b11, 3'b111, 32'h100, 32'h0, 32'h0, 1'b1, 1, 1, 0, 32'h0, 32'h0);
      run(2'b11, OP_SW, 32'h106, 32'h5555, 32'h0, 1'b1, 1, 1, 0, 32'h0, 32'h0);
      for (int i = 0; i < 2; i++) chk32("excp_addr_hold", i, maddr[i], 32'h104);

      // back-to-back loads with req_valid held high
      wait_idle(2'b11);
      for (int i = 0; i < 2; i++) begin a0[i] = acc_count[i]; r0[i] = resp_count[i]; end
      @(negedge clk);
      req_op = OP_LW; req_addr = 32'h100; req_wdata = 32'h0; req_valid = 2'b11;
      repeat (24) @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      wait_idle(2'b11);
      chk32("b2b_accepts", 0, 32'(acc_count[0] - a0[0]), 32'd6);
      chk32("b2b_accepts", 1, 32'(acc_count[1] - a0[1]), 32'd4);
      chk32("b2b_responses", 0, 32'(resp_count[0] - r0[0]), 32'd6);
      chk32("b2b_responses", 1, 32'(resp_count[1] - r0[1]), 32'd4);

      // reset during the write cycle of an sb on the latency-1 instance
      wait_idle(2'b11);
      @(negedge clk);
      req_valid = 2'b01; req_op = OP_SB; req_addr = 32'h102; req_wdata = 32'h55667788;
      @(posedge clk);
      @(negedge clk);
      req_valid = 2'b00;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk1("wr_before_reset", 0, mem_wr[0], 1'b1);
      rc = resp_count[0];
      rstn[0] = 1'b0;
      #1;
      chk1("async_mem_wr", 0, mem_wr[0], 1'b0);
      chk1("async_resp_valid", 0, resp_valid[0], 1'b0);
      chk1("async_ready", 0, rdy[0], 1'b1);
      chk32("async_mem_addr", 0, maddr[0], 32'h0);
      @(negedge clk);
      @(negedge clk);
      rstn[0] = 1'b1;
      #1;
      chk1("ready_after_release", 0, rdy[0], 1'b1);
      repeat (5) @(negedge clk);
      chk32("no_resp_after_abort", 0, 32'(resp_count[0]), 32'(rc));

      run(2'b11, OP_LW, 32'h100, 32'h0, 32'h1122BEEF, 1'b0, 3, 5, 0, 32'h0, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
